// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S widths and frame/sample helpers
// Holds SAMPLE_BITS, SLOT_BITS and FRAME_BITS.
// norm_sample(): converts a sample to two's complement.
// pack_frame(): builds the 64-bit Philips frame from a left/right pair.
package i2s_pkg;
  localparam int SAMPLE_BITS = 16;
  localparam int SLOT_BITS = 32;
  localparam int FRAME_BITS = 64;
  function automatic logic [SAMPLE_BITS-1:0] norm_sample(input logic is_signed, input logic [SAMPLE_BITS-1:0] s);
    return {~is_signed ^ s[SAMPLE_BITS-1], s[SAMPLE_BITS-2:0]};
  endfunction
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [SAMPLE_BITS-1:0] l, input logic [SAMPLE_BITS-1:0] r);
    return {1'b0, l, {(SLOT_BITS-SAMPLE_BITS-1){1'b0}}, 1'b0, r, {(SLOT_BITS-SAMPLE_BITS-1){1'b0}}};
  endfunction
endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample handshake between a producer and the I2S transmitter
// Signals: is_signed, sample_l, sample_r, sample_valid, sample_ready.
// master = producer, slave = transmitter.
interface i2s_tx_if import i2s_pkg::*;;
  logic is_signed;
  logic [SAMPLE_BITS-1:0] sample_l;
  logic [SAMPLE_BITS-1:0] sample_r;
  logic sample_valid;
  logic sample_ready;
  modport master (output is_signed, sample_l, sample_r, sample_valid, input sample_ready);
  modport slave (input is_signed, sample_l, sample_r, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx_timing.sv
// i2s_tx_timing: bit-clock divider, bit counter and word select for the I2S transmitter
// Inputs: clk, reset_n.
// Outputs: bclk_o and lrclk_o.
// Outputs: fall_strobe_o, high on the cycle whose edge drops bclk.
// Outputs: frame_strobe_o, the fall that wraps bit_cnt to 0.
module i2s_tx_timing import i2s_pkg::*; #(
  parameter int unsigned H = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic bclk_o,
  output logic lrclk_o,
  output logic fall_strobe_o,
  output logic frame_strobe_o
);
  localparam int DW = $clog2(H);
  logic [DW-1:0] div_q;
  logic [$clog2(FRAME_BITS)-1:0] bit_cnt_q;
  logic bclk_q;
  logic tick;
  assign tick = div_q == DW'(H - 1);
  assign fall_strobe_o = tick & bclk_q;
  assign frame_strobe_o = fall_strobe_o & (bit_cnt_q == '1);
  assign bclk_o = bclk_q;
  assign lrclk_o = bit_cnt_q[$clog2(FRAME_BITS)-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div_q <= '0;
      bclk_q <= 1'b0;
      bit_cnt_q <= '1;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) bclk_q <= ~bclk_q;
      if (fall_strobe_o) bit_cnt_q <= bit_cnt_q + 1'b1;
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S transmitter with a one-pair holding register
// Inputs: clk, reset_n (async, active-low).
// Bus: sample handshake (slave).
// Outputs: frame_start and underrun pulses.
// Outputs: i2s_bclk, i2s_lrclk and i2s_data.
module i2s_tx import i2s_pkg::*; #(
  parameter int unsigned CLK_RATE = 24576000,
  parameter int unsigned AUDIO_RATE = 48000
) (
  input  logic clk,
  input  logic reset_n,
  i2s_tx_if.slave bus,
  output logic frame_start,
  output logic underrun,
  output logic i2s_bclk,
  output logic i2s_lrclk,
  output logic i2s_data
);
  localparam int unsigned FR = AUDIO_RATE * 128;
  localparam int unsigned H = CLK_RATE / FR;
  if (CLK_RATE % FR != 0 || H < 2) begin : g_bad_rate
    $error("i2s_tx: CLK_RATE must be an exact multiple (>= 2) of AUDIO_RATE*128");
  end
  logic fall_strobe, frame_strobe, accept;
  logic [SAMPLE_BITS-1:0] hold_l_q, hold_r_q;
  logic hold_full_q, data_q, frame_start_q, underrun_q;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  i2s_tx_timing #(.H(H)) u_timing (
    .clk(clk),
    .reset_n(reset_n),
    .bclk_o(i2s_bclk),
    .lrclk_o(i2s_lrclk),
    .fall_strobe_o(fall_strobe),
    .frame_strobe_o(frame_strobe)
  );
  assign accept = bus.sample_valid & ~hold_full_q;
  assign bus.sample_ready = ~hold_full_q;
  assign frame_start = frame_start_q;
  assign underrun = underrun_q;
  assign i2s_data = data_q;
  // A frame load reads the holding register before any same-cycle accept overwrites it.
  always_comb frame_d = frame_strobe ? pack_frame(hold_l_q, hold_r_q) : frame_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hold_l_q <= '0;
      hold_r_q <= '0;
      hold_full_q <= 1'b0;
      frame_q <= '0;
      data_q <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      frame_start_q <= frame_strobe;
      underrun_q <= frame_strobe & ~hold_full_q;
      hold_full_q <= accept | (hold_full_q & ~frame_strobe);
      if (accept) begin
        hold_l_q <= norm_sample(bus.is_signed, bus.sample_l);
        hold_r_q <= norm_sample(bus.is_signed, bus.sample_r);
      end
      if (fall_strobe) begin
        data_q <= frame_d[FRAME_BITS-1];
        frame_q <= frame_d << 1;
      end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized self-checking bench for i2s_tx against a frame-level model
module tb_i2s_tx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_start, underrun, i2s_bclk, i2s_lrclk, i2s_data;
  int pass_cnt = 0;
  int total_cnt = 0;
  localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;

  i2s_tx_if bus();
  i2s_tx dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .frame_start(frame_start),
    .underrun(underrun),
    .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_data(i2s_data)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

  function automatic logic [15:0] mapw(input logic sg, input logic [15:0] x);
    return sg ? x : (x ^ 16'h8000);
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'h0, 1'b0, r, 15'h0};
  endfunction

  // Model: pairs accepted but not yet framed wait in pend_q; each frame takes the oldest,
  // or repeats the last framed pair with an underrun when none is waiting.
  logic acc_now = 1'b0;
  logic [15:0] acc_l, acc_r;
  logic [31:0] pend_q[$];
  logic [15:0] m_l = 16'h0;
  logic [15:0] m_r = 16'h0;
  logic m_ur = 1'b0;

  always @(posedge clk) begin
    acc_now = reset_n & bus.sample_valid & bus.sample_ready;
    acc_l = mapw(bus.is_signed, bus.sample_l);
    acc_r = mapw(bus.is_signed, bus.sample_r);
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      pend_q.delete();
      m_l = 16'h0;
      m_r = 16'h0;
      m_ur = 1'b0;
    end else begin
      if (frame_start) begin
        m_ur = pend_q.size() == 0;
        if (!m_ur) {m_l, m_r} = pend_q.pop_front();
      end
      if (acc_now) pend_q.push_back({acc_l, acc_r});
    end
    acc_now = 1'b0;
  end

  task automatic wait_fall(output int w);
    logic pb;
    w = 0;
    do begin
      pb = i2s_bclk;
      @(negedge clk);
      w++;
    end while (!(pb && !i2s_bclk) && w < 100);
    if (w >= 100) begin
      total_cnt++;
      $display("FAIL bclk_fall_timeout: no falling bclk within %0d clocks", w);
    end
  endtask

  task automatic wait_fs(output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!frame_start && w < 3000);
    if (!frame_start) begin
      total_cnt++;
      $display("FAIL frame_start_timeout: none within %0d clocks", w);
    end
  endtask

  task automatic capture(input bit at_start, output logic [63:0] d, output logic [63:0] lr, output logic ur,
                         output int bper, output logic [15:0] el, output logic [15:0] er, output logic eur);
    int w;
    if (!at_start) wait_fs(w);
    #1;
    el = m_l;
    er = m_r;
    eur = m_ur;
    ur = underrun;
    d = '0;
    lr = '0;
    d[63] = i2s_data;
    lr[63] = i2s_lrclk;
    bper = 0;
    for (int n = 1; n < 64; n++) begin
      wait_fall(w);
      if (n == 1) bper = w;
      d[63-n] = i2s_data;
      lr[63-n] = i2s_lrclk;
    end
  endtask

  task automatic send(input logic sg, input logic [15:0] l, input logic [15:0] r);
    int w = 0;
    bus.is_signed = sg;
    bus.sample_l = l;
    bus.sample_r = r;
    bus.sample_valid = 1'b1;
    while (!bus.sample_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) begin
      total_cnt++;
      $display("FAIL send_timeout: sample_ready stayed 0 for %0d clocks", w);
    end
    @(posedge clk);
    #1 bus.sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    int c, bp;
    logic pl;
    logic [63:0] d, lr;
    logic ur, eur;
    logic [15:0] el, er;
    bus.sample_valid = 1'b0;
    bus.is_signed = 1'b0;
    bus.sample_l = 16'h0;
    bus.sample_r = 16'h0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.sample_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", bus.sample_ready); else pass_cnt++;
    total_cnt++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %b expected 0", frame_start); else pass_cnt++;
    total_cnt++; if (underrun !== 1'b0) $display("FAIL rst_underrun: got %b expected 0", underrun); else pass_cnt++;
    total_cnt++; if (i2s_bclk !== 1'b0) $display("FAIL rst_bclk: got %b expected 0", i2s_bclk); else pass_cnt++;
    total_cnt++; if (i2s_lrclk !== 1'b1) $display("FAIL rst_lrclk: got %b expected 1", i2s_lrclk); else pass_cnt++;
    total_cnt++; if (i2s_data !== 1'b0) $display("FAIL rst_data: got %b expected 0", i2s_data); else pass_cnt++;
    #3 reset_n = 1'b1;
    wait_fs(c);
    total_cnt++; if (c !== 8) $display("FAIL first_frame_clock: got %0d expected 8", c); else pass_cnt++;
    capture(1'b1, d, lr, ur, bp, el, er, eur);
    total_cnt++; if (ur !== 1'b1) $display("FAIL first_underrun: got %b expected 1", ur); else pass_cnt++;
    total_cnt++; if (d !== 64'h0) $display("FAIL first_frame_data: got %h expected 0", d); else pass_cnt++;
    total_cnt++; if (d !== mk(el, er)) $display("FAIL first_frame_model: got %h expected %h", d, mk(el, er)); else pass_cnt++;
    total_cnt++; if (lr !== LR_EXP) $display("FAIL lrclk_slots: got %h expected %h", lr, LR_EXP); else pass_cnt++;
    total_cnt++; if (bp !== 8) $display("FAIL bclk_period: got %0d expected 8", bp); else pass_cnt++;
    c = 0;
    do begin pl = i2s_lrclk; @(negedge clk); c++; end while (!(!pl && i2s_lrclk) && c < 1000);
    c = 0;
    do begin pl = i2s_lrclk; @(negedge clk); c++; end while (!(!pl && i2s_lrclk) && c < 1000);
    total_cnt++; if (c !== 512) $display("FAIL lrclk_period: got %0d expected 512", c); else pass_cnt++;
  endtask

  task automatic test_signed_pair();
    int bp;
    logic [63:0] d, lr;
    logic ur, eur;
    logic [15:0] el, er;
    send(1'b1, 16'hA5C3, 16'h0001);
    capture(1'b0, d, lr, ur, bp, el, er, eur);
    total_cnt++; if (d !== 64'h52E18000_00008000) $display("FAIL signed_frame: got %h expected %h", d, 64'h52E18000_00008000); else pass_cnt++;
    total_cnt++; if (ur !== 1'b0) $display("FAIL signed_underrun: got %b expected 0", ur); else pass_cnt++;
    total_cnt++; if (d !== mk(el, er) || ur !== eur) $display("FAIL signed_model: got %h/%b expected %h/%b", d, ur, mk(el, er), eur); else pass_cnt++;
  endtask

  task automatic test_unsigned();
    int bp;
    logic [63:0] d, lr;
    logic ur, eur;
    logic [15:0] el, er, r;
    r = 16'($urandom);
    send(1'b0, 16'h8000, r);
    capture(1'b0, d, lr, ur, bp, el, er, eur);
    total_cnt++; if (d[62:47] !== 16'h0000) $display("FAIL unsigned_8000: got %h expected 0000", d[62:47]); else pass_cnt++;
    total_cnt++; if (d !== mk(16'h0000, r ^ 16'h8000)) $display("FAIL unsigned_frame1: got %h expected %h", d, mk(16'h0000, r ^ 16'h8000)); else pass_cnt++;
    r = 16'($urandom);
    send(1'b0, 16'h0000, r);
    capture(1'b0, d, lr, ur, bp, el, er, eur);
    total_cnt++; if (d[62:47] !== 16'h8000) $display("FAIL unsigned_0000: got %h expected 8000", d[62:47]); else pass_cnt++;
    total_cnt++; if (d !== mk(el, er) || ur !== eur) $display("FAIL unsigned_model: got %h/%b expected %h/%b", d, ur, mk(el, er), eur); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bp;
    logic [63:0] d, lr;
    logic ur, eur;
    logic [15:0] el, er, base;
    time t[4];
    base = 16'($urandom);
    fork
      begin
        int w;
        bus.is_signed = 1'b1;
        bus.sample_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
          bus.sample_l = base + 16'(k);
          bus.sample_r = ~(base + 16'(k));
          w = 0;
          while (!bus.sample_ready && w < 2000) begin
            @(negedge clk);
            w++;
          end
          @(posedge clk);
          t[k] = $time;
          #1;
        end
        bus.sample_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          capture(1'b0, d, lr, ur, bp, el, er, eur);
          total_cnt++; if (d[62:47] !== base + 16'(i)) $display("FAIL b2b_left%0d: got %h expected %h", i, d[62:47], base + 16'(i)); else pass_cnt++;
          total_cnt++; if (ur !== 1'b0) $display("FAIL b2b_underrun%0d: got %b expected 0", i, ur); else pass_cnt++;
          total_cnt++; if (d !== mk(el, er) || ur !== eur) $display("FAIL b2b_model%0d: got %h/%b expected %h/%b", i, d, ur, mk(el, er), eur); else pass_cnt++;
        end
      end
    join
    total_cnt++; if (t[2] - t[1] !== 5120) $display("FAIL b2b_accept_gap1: got %0t expected 5120", t[2] - t[1]); else pass_cnt++;
    total_cnt++; if (t[3] - t[2] !== 5120) $display("FAIL b2b_accept_gap2: got %0t expected 5120", t[3] - t[2]); else pass_cnt++;
  endtask

  task automatic test_stall();
    int bp;
    logic [63:0] d, lr;
    logic ur, eur;
    logic [15:0] el, er, r;
    r = 16'($urandom);
    send(1'b1, 16'h1234, r);
    for (int i = 0; i < 3; i++) begin
      capture(1'b0, d, lr, ur, bp, el, er, eur);
      total_cnt++; if (d !== mk(16'h1234, r)) $display("FAIL stall_frame%0d: got %h expected %h", i, d, mk(16'h1234, r)); else pass_cnt++;
      total_cnt++; if (ur !== (i != 0)) $display("FAIL stall_underrun%0d: got %b expected %b", i, ur, i != 0); else pass_cnt++;
      total_cnt++; if (ur !== eur) $display("FAIL stall_model%0d: got %b expected %b", i, ur, eur); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int bp;
    logic [63:0] d, lr;
    logic ur, eur, sg;
    logic [15:0] el, er, l, r;
    for (int i = 0; i < 3; i++) begin
      sg = 1'($urandom);
      l = 16'($urandom);
      r = 16'($urandom);
      send(sg, l, r);
      capture(1'b0, d, lr, ur, bp, el, er, eur);
      total_cnt++; if (d !== mk(mapw(sg, l), mapw(sg, r))) $display("FAIL rand_frame%0d: got %h expected %h", i, d, mk(mapw(sg, l), mapw(sg, r))); else pass_cnt++;
      total_cnt++; if (d !== mk(el, er) || ur !== eur) $display("FAIL rand_model%0d: got %h/%b expected %h/%b", i, d, ur, mk(el, er), eur); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int c, bp;
    logic [63:0] d, lr;
    logic ur, eur;
    logic [15:0] el, er;
    send(1'b1, 16'($urandom), 16'($urandom));
    wait_fs(c);
    send(1'b1, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 20; i++) wait_fall(c);
    total_cnt++; if (i2s_lrclk !== 1'b0 || bus.sample_ready !== 1'b0) $display("FAIL mid_pre_state: got lrclk %b ready %b expected 0 0", i2s_lrclk, bus.sample_ready); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (bus.sample_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b expected 1", bus.sample_ready); else pass_cnt++;
    total_cnt++; if (i2s_lrclk !== 1'b1) $display("FAIL mid_rst_lrclk: got %b expected 1", i2s_lrclk); else pass_cnt++;
    total_cnt++; if (i2s_bclk !== 1'b0 || i2s_data !== 1'b0) $display("FAIL mid_rst_bclk_data: got %b %b expected 0 0", i2s_bclk, i2s_data); else pass_cnt++;
    total_cnt++; if (frame_start !== 1'b0 || underrun !== 1'b0) $display("FAIL mid_rst_pulses: got %b %b expected 0 0", frame_start, underrun); else pass_cnt++;
    repeat (3) @(negedge clk);
    #3 reset_n = 1'b1;
    wait_fs(c);
    total_cnt++; if (c !== 8) $display("FAIL mid_restart_clock: got %0d expected 8", c); else pass_cnt++;
    capture(1'b1, d, lr, ur, bp, el, er, eur);
    total_cnt++; if (d !== 64'h0 || ur !== 1'b1) $display("FAIL mid_restart_frame: got %h/%b expected 0/1", d, ur); else pass_cnt++;
    total_cnt++; if (d !== mk(el, er) || ur !== eur) $display("FAIL mid_restart_model: got %h/%b expected %h/%b", d, ur, mk(el, er), eur); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_signed_pair();
    test_unsigned();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter CLK_RATE, default 24576000, system clock frequency in Hz.
REQ-002 Parameter AUDIO_RATE, default 48000, sample frame rate in Hz.
REQ-003 clk  input  1  system clock; the single clock, all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 is_signed  input  1  1 = sample inputs are two's complement; 0 = offset binary.
REQ-006 sample_l  input  16  left sample.
REQ-007 sample_r  input  16  right sample.
REQ-008 sample_valid  input  1  producer offers the sample_l/sample_r pair.
REQ-009 sample_ready  output  1  holding register empty, pair can be accepted.
REQ-010 frame_start  output  1  one-cycle pulse when a new frame is loaded for transmission.
REQ-011 underrun  output  1  one-cycle pulse when a frame loads with no new pair held.
REQ-012 i2s_bclk  output  1  bit clock, 64 x AUDIO_RATE.
REQ-013 i2s_lrclk  output  1  word select; 0 = left slot, 1 = right slot.
REQ-014 i2s_data  output  1  serial data, MSB first, Philips I2S alignment.

Function
REQ-015 H = CLK_RATE/(AUDIO_RATE*128); elaboration SHALL fail if the division has a remainder or H < 2.
REQ-016 Divider counts 0..H-1; i2s_bclk toggles on the cycle div==H-1, giving a period of 2H clocks (8 clocks at defaults).
REQ-017 bit_cnt (6 bits) advances on every bclk falling edge (the 1->0 toggle) and wraps 63->0.
REQ-018 i2s_lrclk, i2s_data and bit_cnt all update on the same cycle as the bclk falling edge, and never on a rising edge.
REQ-019 i2s_lrclk = 1 for bit_cnt 32..63 and 0 for bit_cnt 0..31.
REQ-020 Frame word F[63:0] = {1'b0, L[15:0], 15'b0, 1'b0, R[15:0], 15'b0}.
REQ-021 i2s_data at bit_cnt n = F[63-n], so the MSB follows the lrclk edge by one bclk.
REQ-022 Accept on a cycle with sample_valid & sample_ready: store {~is_signed^sample_l[15], sample_l[14:0]} and the same form of sample_r, then set hold_full.
REQ-023 sample_ready = ~hold_full; it is a registered function and has no combinational path from sample_valid.
REQ-024 On the falling edge where bit_cnt wraps to 0, F loads from the holding register, hold_full clears, and frame_start pulses.
REQ-025 If hold_full = 0 at the load, F loads the stale holding contents (the previous pair is repeated) and underrun pulses together with frame_start.
REQ-026 If an accept and a load fall on the same cycle, the load uses the old holding contents with underrun, and hold_full is 1 afterwards.
REQ-027 Throughput is at most one pair per frame; sample_valid held high SHALL NOT cause a pair to be lost or duplicated.

Reset
REQ-028 While reset_n = 0: div = 0, bit_cnt = 63, i2s_bclk = 0, i2s_lrclk = 1, i2s_data = 0, holding register = 0, hold_full = 0, F = 0.
REQ-029 While reset_n = 0: sample_ready = 1, frame_start = 0, underrun = 0.
REQ-030 After reset release, the first bclk falling edge occurs 2H clocks later and performs the first frame load.
REQ-031 Asserting reset mid-frame SHALL abort the frame immediately; no partial state survives.

Structure
REQ-032 Shared package i2s_pkg holds SAMPLE_BITS=16, SLOT_BITS=32 and FRAME_BITS=64.
REQ-033 Sub-module i2s_tx_timing contains the divider, bclk, bit_cnt and lrclk, and outputs the fall_strobe and frame_strobe pulses.
REQ-034 Holding register, handshake and shift register live in i2s_tx.

Verification
REQ-035 Reset, then hold sample_valid=0 -> first frame_start at clock 8 with underrun=1; data stays all zero; bclk period is 8 clocks; lrclk period is 512 clocks.
REQ-036 is_signed=1, L=16'hA5C3, R=16'h0001 accepted before the first load.
REQ-037 Expected response for REQ-036: next frame shows data bits 1..16 = A5C3 and bits 33..48 = 0001; all other bits 0; bit 0 and bit 32 are 0.
REQ-038 is_signed=0, L=16'h8000 -> serialized left word is 16'h0000; L=16'h0000 -> 16'h8000.
REQ-039 sample_valid held high with an incrementing pair each accept -> exactly one accept per 512 clocks; frames carry consecutive values; no underrun after the first frame.
REQ-040 Producer stalls for two frames after supplying L=16'h1234 -> that frame, then two repeats of 1234, each repeat with an underrun pulse.
REQ-041 reset_n pulsed low at bit_cnt 20 -> outputs take the REQ-028/REQ-029 values asynchronously; the restart follows REQ-030 timing.
